dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-ported data memory (`data_mem`). It shares the memory between the CPU load/store port and a DMA/debug port, and issues exactly one access at a time. It follows the memory's timing: a read takes one cycle, and a write takes two cycles because the memory does a read-modify-write and raises `clk_stall`. Each requester gets a one-cycle `ack` when its access completes; for reads, `ack` comes with registered read data.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, port indices,
// sign_mask field values and the memory-mapped LED address.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ISSUE      = 2'd1;
    localparam logic [1:0] ST_READ_RSP   = 2'd2;
    localparam logic [1:0] ST_WRITE_WAIT = 2'd3;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam logic [3:0] SM_BYTE   = 4'b0001;
    localparam logic [3:0] SM_HALF   = 4'b0010;
    localparam logic [3:0] SM_WORD   = 4'b0100;
    localparam int         SM_SIGNED = 3;

    localparam logic [31:0] LED_ADDR = 32'h0000_2000;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational grant: a lone requester wins; a tie goes to the port
// other than `last` (round-robin) or always to the CPU when FIXED_PRIO is set.
module rr_arb2
    import dmem_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_port
);

    always_comb begin
        grant_valid = |req;
        grant_port  = PORT_CPU;
        if (req == 2'b10) begin
            grant_port = PORT_DMA;
        end else if (req == 2'b11) begin
            grant_port = (FIXED_PRIO != 0) ? PORT_CPU : ~last;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU and DMA ports, issuing
// one access at a time and sequencing the memory's one-cycle read / stalled write.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [3:0]    cpu_sign_mask,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic [3:0]    dma_sign_mask,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_write_data,
    output logic          mem_memread,
    output logic          mem_memwrite,
    output logic [3:0]    mem_sign_mask,
    input  logic [DW-1:0] mem_read_data,
    input  logic          mem_clk_stall
);

    logic [1:0]          state_reg;
    logic                owner_reg;
    logic                last_reg;
    logic                cmd_we_reg;
    logic [AW-1:0]       cmd_addr_reg;
    logic [DW-1:0]       cmd_wdata_reg;
    logic [3:0]          cmd_sm_reg;

    logic                grant_valid;
    logic                grant_port;
    logic                grant_fire;
    logic                capture_read;
    logic                rsp_done;
    logic [1:0]          ack_vec;
    logic [1:0][DW-1:0]  rdata_vec;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .req         ({dma_req, cpu_req}),
        .last        (last_reg),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // No grant while the memory is still finishing an earlier write.
    assign grant_fire   = (state_reg == ST_IDLE) && grant_valid && !mem_clk_stall;
    assign capture_read = (state_reg == ST_ISSUE) && !cmd_we_reg;
    assign rsp_done     = (state_reg == ST_READ_RSP) ||
                          ((state_reg == ST_WRITE_WAIT) && !mem_clk_stall);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= PORT_CPU;
            last_reg      <= PORT_DMA;
            cmd_we_reg    <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
            cmd_sm_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_fire) begin
                        owner_reg <= grant_port;
                        last_reg  <= grant_port;
                        state_reg <= ST_ISSUE;
                        if (grant_port == PORT_DMA) begin
                            cmd_we_reg    <= dma_we;
                            cmd_addr_reg  <= dma_addr;
                            cmd_wdata_reg <= dma_wdata;
                            cmd_sm_reg    <= dma_sign_mask;
                        end else begin
                            cmd_we_reg    <= cpu_we;
                            cmd_addr_reg  <= cpu_addr;
                            cmd_wdata_reg <= cpu_wdata;
                            cmd_sm_reg    <= cpu_sign_mask;
                        end
                    end
                end
                ST_ISSUE:      state_reg <= cmd_we_reg ? ST_WRITE_WAIT : ST_READ_RSP;
                ST_READ_RSP:   state_reg <= ST_IDLE;
                ST_WRITE_WAIT: if (!mem_clk_stall) state_reg <= ST_IDLE;
                default:       state_reg <= ST_IDLE;
            endcase
        end
    end

    // Read data is captured on the edge that enters READ_RSP so it is already
    // registered in the cycle the ack pulses.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DW-1:0] rdata_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_reg <= '0;
                end else if (capture_read && (owner_reg == 1'(gi))) begin
                    rdata_reg <= mem_read_data;
                end
            end

            assign rdata_vec[gi] = rdata_reg;
            assign ack_vec[gi]   = rsp_done && (owner_reg == 1'(gi));
        end
    endgenerate

    assign cpu_ack   = ack_vec[PORT_CPU];
    assign dma_ack   = ack_vec[PORT_DMA];
    assign cpu_rdata = rdata_vec[PORT_CPU];
    assign dma_rdata = rdata_vec[PORT_DMA];

    assign mem_addr       = cmd_addr_reg;
    assign mem_write_data = cmd_wdata_reg;
    assign mem_sign_mask  = cmd_sm_reg;
    assign mem_memread    = (state_reg == ST_ISSUE) && !cmd_we_reg;
    assign mem_memwrite   = (state_reg == ST_ISSUE) && cmd_we_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural data memory with a configurable write
// stall, per-scenario tasks and a randomized transaction run.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    typedef struct {
        int          strobe_off;
        int          strobe_cnt;
        int          ack_off;
        bit          other_ack;
        bit          ack_after;
        bit          s_write;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_sm;
        logic [31:0] rd;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
    logic [3:0]  cpu_sign_mask = '0, dma_sign_mask = '0;

    logic        cpu_ack, dma_ack, cpu_ack2, dma_ack2;
    logic [31:0] cpu_rdata, dma_rdata, cpu_rdata2, dma_rdata2;
    logic [31:0] mem1_addr, mem1_write_data, mem1_read_data;
    logic [31:0] mem2_addr, mem2_write_data, mem2_read_data;
    logic        mem1_memread, mem1_memwrite, mem1_clk_stall;
    logic        mem2_memread, mem2_memwrite, mem2_clk_stall;
    logic [3:0]  mem1_sign_mask, mem2_sign_mask;

    logic [31:0] mem [64];
    logic [31:0] exp_rdata [2];
    int          stall_len = 1;
    int          stall_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Memory model: combinational read, and a write raises the stall for stall_len cycles.
    assign mem1_read_data = mem[mem1_addr[7:2]];
    assign mem2_read_data = mem[mem2_addr[7:2]];
    assign mem1_clk_stall = (stall_cnt != 0);
    assign mem2_clk_stall = 1'b0;

    always @(posedge clk) begin
        if (mem1_memwrite) stall_cnt <= stall_len;
        else if (stall_cnt > 0) stall_cnt <= stall_cnt - 1;
    end

    dmem_arbiter #(.FIXED_PRIO(0), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_sign_mask(cpu_sign_mask), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_sign_mask(dma_sign_mask), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_addr(mem1_addr), .mem_write_data(mem1_write_data), .mem_memread(mem1_memread),
        .mem_memwrite(mem1_memwrite), .mem_sign_mask(mem1_sign_mask),
        .mem_read_data(mem1_read_data), .mem_clk_stall(mem1_clk_stall)
    );

    dmem_arbiter #(.FIXED_PRIO(1), .AW(32), .DW(32)) dut_fixed (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_sign_mask(cpu_sign_mask), .cpu_ack(cpu_ack2), .cpu_rdata(cpu_rdata2),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_sign_mask(dma_sign_mask), .dma_ack(dma_ack2), .dma_rdata(dma_rdata2),
        .mem_addr(mem2_addr), .mem_write_data(mem2_write_data), .mem_memread(mem2_memread),
        .mem_memwrite(mem2_memwrite), .mem_sign_mask(mem2_sign_mask),
        .mem_read_data(mem2_read_data), .mem_clk_stall(mem2_clk_stall)
    );

    // Drives one request from an idle cycle and records what the main DUT does.
    task automatic run_single(input bit port, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] sm, output obs_t o);
        o.strobe_off = -1; o.strobe_cnt = 0; o.ack_off = -1; o.other_ack = 0; o.ack_after = 0;
        o.s_write = 0; o.s_addr = '0; o.s_wdata = '0; o.s_sm = '0; o.rd = '0;
        if (port) begin
            dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_sign_mask = sm;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_sign_mask = sm;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem1_memread || mem1_memwrite) begin
                o.strobe_cnt++; o.strobe_off = k; o.s_write = mem1_memwrite;
                o.s_addr = mem1_addr; o.s_wdata = mem1_write_data; o.s_sm = mem1_sign_mask;
            end
            if (port ? cpu_ack : dma_ack) o.other_ack = 1;
            if (port ? dma_ack : cpu_ack) begin
                o.ack_off = k; o.rd = port ? dma_rdata : cpu_rdata;
                break;
            end
        end
        cpu_req = 0; dma_req = 0;
        @(negedge clk);
        o.ack_after = cpu_ack | dma_ack;
        if (mem1_memread || mem1_memwrite) o.strobe_cnt++;
    endtask

    task automatic test_reset();
        reset = 1;
        @(negedge clk);
        checks++;
        if ({cpu_ack, dma_ack, mem1_memread, mem1_memwrite} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {cpu_ack, dma_ack, mem1_memread, mem1_memwrite});
        end
        checks++;
        if ({mem1_addr, mem1_write_data, mem1_sign_mask} !== 68'h0) begin
            errors++; $display("FAIL reset_mem_bus: got %h/%h/%h expected 0", mem1_addr, mem1_write_data, mem1_sign_mask);
        end
        checks++;
        if ({cpu_rdata, dma_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h expected 0", cpu_rdata, dma_rdata);
        end
        reset = 0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        @(negedge clk);
        $display("txn reset done");
    endtask

    task automatic test_cpu_load();
        obs_t o;
        mem[4] = 32'hDEAD_BEEF;
        run_single(1'b0, 1'b0, 32'h10, 32'h0, SM_WORD, o);
        exp_rdata[0] = 32'hDEAD_BEEF;
        checks++;
        if (o.strobe_off !== 1 || o.strobe_cnt !== 1 || o.s_write !== 1'b0) begin
            errors++; $display("FAIL load_strobe: got off=%0d cnt=%0d wr=%0b expected off=1 cnt=1 wr=0", o.strobe_off, o.strobe_cnt, o.s_write);
        end
        checks++;
        if (o.ack_off !== 2) begin
            errors++; $display("FAIL load_ack_time: got %0d expected 2", o.ack_off);
        end
        checks++;
        if (o.rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL load_rdata: got %h expected deadbeef", o.rd);
        end
        checks++;
        if (o.other_ack !== 1'b0 || o.ack_after !== 1'b0) begin
            errors++; $display("FAIL load_ack_pulse: got other=%0b after=%0b expected 0 0", o.other_ack, o.ack_after);
        end
        checks++;
        if (cpu_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL load_rdata_hold: got %h expected deadbeef", cpu_rdata);
        end
        $display("txn cpu load addr=00000010 ack@%0d rdata=%h", o.ack_off, o.rd);
    endtask

    task automatic test_dma_store();
        obs_t o;
        stall_len = 1;
        run_single(1'b1, 1'b1, 32'h21, 32'hA5, SM_BYTE, o);
        checks++;
        if (o.strobe_off !== 1 || o.strobe_cnt !== 1 || o.s_write !== 1'b1) begin
            errors++; $display("FAIL store_strobe: got off=%0d cnt=%0d wr=%0b expected off=1 cnt=1 wr=1", o.strobe_off, o.strobe_cnt, o.s_write);
        end
        checks++;
        if (o.s_addr !== 32'h21 || o.s_wdata !== 32'hA5 || o.s_sm !== SM_BYTE) begin
            errors++; $display("FAIL store_fields: got %h/%h/%b expected 00000021/000000a5/0001", o.s_addr, o.s_wdata, o.s_sm);
        end
        checks++;
        if (o.ack_off !== 3 || o.other_ack !== 1'b0 || o.ack_after !== 1'b0) begin
            errors++; $display("FAIL store_ack: got off=%0d other=%0b after=%0b expected 3 0 0", o.ack_off, o.other_ack, o.ack_after);
        end
        $display("txn dma store addr=00000021 data=a5 ack@%0d", o.ack_off);
    endtask

    task automatic test_led_store();
        obs_t o;
        stall_len = 1;
        run_single(1'b0, 1'b1, LED_ADDR, 32'h5A, SM_WORD, o);
        checks++;
        if (o.s_addr !== 32'h2000 || o.s_wdata !== 32'h5A || o.s_write !== 1'b1) begin
            errors++; $display("FAIL led_fields: got %h/%h wr=%0b expected 00002000/0000005a wr=1", o.s_addr, o.s_wdata, o.s_write);
        end
        checks++;
        if (o.strobe_cnt !== 1 || o.ack_off !== 3) begin
            errors++; $display("FAIL led_timing: got cnt=%0d ack=%0d expected cnt=1 ack=3", o.strobe_cnt, o.ack_off);
        end
        $display("txn cpu led store ack@%0d", o.ack_off);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        int          off [4];
        logic [31:0] rd [4];
        int          n = 0;
        for (int i = 0; i < 4; i++) a[i] = 32'h100 + 32'(i * 4 + 8);
        cpu_req = 1; cpu_we = 0; cpu_sign_mask = SM_WORD; cpu_addr = a[0];
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (cpu_ack) begin
                off[n] = k; rd[n] = cpu_rdata; n++;
                if (n == 4) break;
                cpu_addr = a[n];
            end
        end
        cpu_req = 0;
        @(negedge clk);
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL b2b_count: got %0d acks expected 4", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (off[i] !== 2 + 3 * i || rd[i] !== mem[a[i][7:2]]) begin
                errors++; $display("FAIL b2b_%0d: got ack@%0d data=%h expected ack@%0d data=%h", i, off[i], rd[i], 2 + 3 * i, mem[a[i][7:2]]);
            end
            $display("txn b2b load %0d ack@%0d rdata=%h", i, off[i], rd[i]);
        end
        if (n > 0) exp_rdata[0] = rd[n-1];
    endtask

    task automatic test_tie();
        bit          port1 [6];
        int          off1 [6];
        logic [31:0] rd1 [6];
        bit          port2 [6];
        int          n1 = 0, n2 = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; cpu_sign_mask = SM_WORD;
        dma_req = 1; dma_we = 0; dma_addr = 32'h80; dma_sign_mask = SM_WORD;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if ((cpu_ack || dma_ack) && n1 < 6) begin
                port1[n1] = dma_ack; off1[n1] = k; rd1[n1] = dma_ack ? dma_rdata : cpu_rdata; n1++;
            end
            if ((cpu_ack2 || dma_ack2) && n2 < 6) begin
                port2[n2] = dma_ack2; n2++;
            end
            if (n1 >= 6) break;
        end
        cpu_req = 0; dma_req = 0;
        @(negedge clk);
        checks++;
        if (n1 !== 6 || n2 !== 6) begin
            errors++; $display("FAIL tie_count: got rr=%0d fixed=%0d expected 6 6", n1, n2);
        end
        for (int i = 0; i < n1; i++) begin
            logic [31:0] want;
            want = (i % 2 == 1) ? mem[32] : mem[16];
            checks++;
            if (port1[i] !== 1'(i % 2) || off1[i] !== 2 + 3 * i || rd1[i] !== want) begin
                errors++; $display("FAIL tie_rr_%0d: got port=%0d ack@%0d data=%h expected port=%0d ack@%0d data=%h", i, port1[i], off1[i], rd1[i], i % 2, 2 + 3 * i, want);
            end
            $display("txn tie rr grant %0d port=%0d ack@%0d", i, port1[i], off1[i]);
        end
        for (int i = 0; i < n2; i++) begin
            checks++;
            if (port2[i] !== 1'b0) begin
                errors++; $display("FAIL tie_fixed_%0d: got port=%0d expected port=0", i, port2[i]);
            end
        end
        exp_rdata[0] = mem[16]; exp_rdata[1] = mem[32];
    endtask

    task automatic test_reset_mid_write();
        int first_rd = -1, first_ack = -1;
        logic [31:0] rd = '0;
        stall_len = 3;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = $urandom; cpu_sign_mask = SM_WORD;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        #1;
        checks++;
        if ({cpu_ack, dma_ack, mem1_memread, mem1_memwrite} !== 4'b0000 ||
            {mem1_addr, mem1_write_data, mem1_sign_mask, cpu_rdata, dma_rdata} !== 132'h0) begin
            errors++; $display("FAIL midrst_outputs: got ack=%b%b strb=%b%b addr=%h wd=%h rd=%h/%h expected all 0",
                cpu_ack, dma_ack, mem1_memread, mem1_memwrite, mem1_addr, mem1_write_data, cpu_rdata, dma_rdata);
        end
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        cpu_we = 0; cpu_addr = 32'h44;
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++; $display("FAIL midrst_no_ack: got %b expected 0", cpu_ack);
        end
        reset = 0;
        for (int k = 4; k <= 20; k++) begin
            @(negedge clk);
            if (mem1_memread && first_rd < 0) first_rd = k;
            if (cpu_ack && first_ack < 0) begin first_ack = k; rd = cpu_rdata; break; end
        end
        cpu_req = 0;
        @(negedge clk);
        exp_rdata[0] = mem[17];
        checks++;
        if (first_rd !== 3 + stall_len || first_ack !== 4 + stall_len) begin
            errors++; $display("FAIL midrst_regrant: got read@%0d ack@%0d expected read@%0d ack@%0d", first_rd, first_ack, 3 + stall_len, 4 + stall_len);
        end
        checks++;
        if (rd !== mem[17]) begin
            errors++; $display("FAIL midrst_rdata: got %h expected %h", rd, mem[17]);
        end
        $display("txn reset during write, regrant read@%0d ack@%0d", first_rd, first_ack);
    endtask

    task automatic test_random(input int n);
        obs_t o;
        for (int t = 0; t < n; t++) begin
            bit          port, we;
            logic [31:0] addr, wdata;
            logic [3:0]  sm;
            int          exp_ack;
            port = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = $urandom;
            wdata = $urandom;
            case ($urandom_range(0, 2))
                0:       sm = SM_BYTE;
                1:       sm = SM_HALF;
                default: sm = SM_WORD;
            endcase
            sm[SM_SIGNED] = 1'($urandom_range(0, 1));
            stall_len = $urandom_range(0, 3);
            // Loads answer two cycles after the request; stores add the memory stall.
            exp_ack = we ? 2 + stall_len : 2;
            run_single(port, we, addr, wdata, sm, o);
            if (!we) exp_rdata[port] = mem[addr[7:2]];
            checks++;
            if (o.strobe_off !== 1 || o.strobe_cnt !== 1 || o.s_write !== we) begin
                errors++; $display("FAIL rnd%0d_strobe: got off=%0d cnt=%0d wr=%0b expected off=1 cnt=1 wr=%0b", t, o.strobe_off, o.strobe_cnt, o.s_write, we);
            end
            checks++;
            if (o.s_addr !== addr || o.s_sm !== sm || (we && o.s_wdata !== wdata)) begin
                errors++; $display("FAIL rnd%0d_fields: got %h/%b/%h expected %h/%b/%h", t, o.s_addr, o.s_sm, o.s_wdata, addr, sm, wdata);
            end
            checks++;
            if (o.ack_off !== exp_ack || o.other_ack !== 1'b0 || o.ack_after !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_ack: got @%0d other=%0b after=%0b expected @%0d 0 0", t, o.ack_off, o.other_ack, o.ack_after, exp_ack);
            end
            checks++;
            if (cpu_rdata !== exp_rdata[0] || dma_rdata !== exp_rdata[1]) begin
                errors++; $display("FAIL rnd%0d_rdata: got %h/%h expected %h/%h", t, cpu_rdata, dma_rdata, exp_rdata[0], exp_rdata[1]);
            end
            $display("txn rnd %0d port=%0d we=%0b addr=%h stall=%0d ack@%0d", t, port, we, addr, stall_len, o.ack_off);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        @(negedge clk);
        test_reset();
        test_cpu_load();
        test_dma_store();
        test_led_store();
        test_back_to_back();
        test_tie();
        test_reset_mid_write();
        test_random(40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
